// File: rtl/hb_fetch_sequencer.sv
// Boot copy, instruction fetch and execute-phase sequencer.
// Owns the PC, phase counter and opcode latch; ucode steers it through strobes.
module hb_fetch_sequencer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned PHASE_W  = 4,
    parameter int unsigned BOOT_LEN = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_rdy,
    input  logic [DATA_W-1:0]  databus,
    input  logic               phase_reset_req,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_load_val,
    input  logic               pc_inc,
    input  logic               halt_req,
    input  logic               run,
    output logic [ADDR_W-1:0]  pc,
    output logic [PHASE_W-1:0] phase,
    output logic [DATA_W-1:0]  instruction,
    output logic               boot_wr,
    output logic               boot_done,
    output logic               fetch_en,
    output logic               halted,
    output logic               phase_ovf
);

    localparam logic [ADDR_W-1:0]  BOOT_LAST = ADDR_W'(BOOT_LEN - 1);
    localparam logic [PHASE_W-1:0] PMAX      = '1;

    typedef enum logic [2:0] {
        S_BOOT,
        S_BOOT_END,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nx;
    logic [PHASE_W-1:0]  r_phase;
    logic [PHASE_W-1:0]  w_phase_nx;
    logic [DATA_W-1:0]   r_instr;
    logic [DATA_W-1:0]   w_instr_nx;
    logic                r_boot_done;
    logic                w_boot_done_nx;
    logic                r_phase_ovf;
    logic                w_phase_ovf_nx;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_pc        <= '0;
            r_phase     <= '0;
            r_instr     <= '0;
            r_boot_done <= 1'b0;
            r_phase_ovf <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pc        <= w_pc_nx;
            r_phase     <= w_phase_nx;
            r_instr     <= w_instr_nx;
            r_boot_done <= w_boot_done_nx;
            r_phase_ovf <= w_phase_ovf_nx;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nx     = r_state;
        w_pc_nx        = r_pc;
        w_phase_nx     = r_phase;
        w_instr_nx     = r_instr;
        w_boot_done_nx = r_boot_done;
        w_phase_ovf_nx = r_phase_ovf;

        case (r_state)
            S_BOOT: begin
                if (mem_rdy) begin
                    if (r_pc == BOOT_LAST) begin
                        w_pc_nx    = '0;
                        w_state_nx = S_BOOT_END;
                    end else begin
                        w_pc_nx = r_pc + ADDR_W'(1);
                    end
                end
            end
            S_BOOT_END: begin
                w_boot_done_nx = 1'b1;
                w_state_nx     = S_FETCH;
            end
            S_FETCH: begin
                if (mem_rdy) begin
                    w_instr_nx = databus;
                    w_pc_nx    = r_pc + ADDR_W'(1);
                    w_phase_nx = PHASE_W'(1);
                    w_state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                // halt beats the wait state; a stalled cycle drops all strobes
                if (halt_req) begin
                    w_state_nx = S_HALT;
                end else if (mem_rdy) begin
                    if (pc_load) begin
                        w_pc_nx = pc_load_val;
                    end else if (pc_inc) begin
                        w_pc_nx = r_pc + ADDR_W'(1);
                    end
                    if (phase_reset_req) begin
                        w_phase_nx = '0;
                        w_state_nx = S_FETCH;
                    end else if (r_phase == PMAX) begin
                        w_phase_ovf_nx = 1'b1;
                        w_phase_nx     = '0;
                        w_state_nx     = S_FETCH;
                    end else begin
                        w_phase_nx = r_phase + PHASE_W'(1);
                    end
                end
            end
            S_HALT: begin
                if (run) begin
                    w_phase_nx = '0;
                    w_state_nx = S_FETCH;
                end
            end
            default: begin
                w_state_nx = S_BOOT;
            end
        endcase
    end

    assign pc          = r_pc;
    assign phase       = r_phase;
    assign instruction = r_instr;
    assign boot_done   = r_boot_done;
    assign phase_ovf   = r_phase_ovf;
    assign boot_wr     = (r_state == S_BOOT) && mem_rdy;
    assign fetch_en    = (r_state == S_FETCH);
    assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_hb_fetch_sequencer.sv
// Vector-table bench for hb_fetch_sequencer with BOOT_LEN=4; expected post-edge
// outputs are queued when each vector is driven and checked after the edge.
module tb_hb_fetch_sequencer;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned PHASE_W  = 4;
    localparam int unsigned BOOT_LEN = 4;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [7:0]  db;
        logic        prr;
        logic        ld;
        logic [11:0] ldv;
        logic        inc;
        logic        hlt;
        logic        run;
    } in_t;

    typedef struct {
        int          idx;
        logic        bwr_chk;
        logic        bwr;
        logic [11:0] pc;
        logic [3:0]  ph;
        logic [7:0]  ins;
        logic        bd;
        logic        ovf;
        logic        fe;
        logic        hl;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic               clk;
    logic               rst;
    logic               mem_rdy;
    logic [DATA_W-1:0]  databus;
    logic               phase_reset_req;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc_load_val;
    logic               pc_inc;
    logic               halt_req;
    logic               run;
    logic [ADDR_W-1:0]  pc;
    logic [PHASE_W-1:0] phase;
    logic [DATA_W-1:0]  instruction;
    logic               boot_wr;
    logic               boot_done;
    logic               fetch_en;
    logic               halted;
    logic               phase_ovf;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    exp_t sbq[$];

    hb_fetch_sequencer #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .PHASE_W (PHASE_W),
        .BOOT_LEN(BOOT_LEN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_rdy        (mem_rdy),
        .databus        (databus),
        .phase_reset_req(phase_reset_req),
        .pc_load        (pc_load),
        .pc_load_val    (pc_load_val),
        .pc_inc         (pc_inc),
        .halt_req       (halt_req),
        .run            (run),
        .pc             (pc),
        .phase          (phase),
        .instruction    (instruction),
        .boot_wr        (boot_wr),
        .boot_done      (boot_done),
        .fetch_en       (fetch_en),
        .halted         (halted),
        .phase_ovf      (phase_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s actual=%h expected=%h", idx, name, act, exp);
        end
    endtask

    // Add one vector: inputs then expected (boot_wr before the edge, registers after it)
    task automatic add(input logic r, input logic rdy, input logic [7:0] db, input logic prr,
                       input logic ld, input logic [11:0] ldv, input logic inc,
                       input logic hlt, input logic rn,
                       input logic bchk, input logic bwr, input logic [11:0] epc,
                       input logic [3:0] eph, input logic [7:0] eins, input logic ebd,
                       input logic eovf, input logic efe, input logic ehl);
        vec_t v;
        v.i = '{rst: r, rdy: rdy, db: db, prr: prr, ld: ld, ldv: ldv, inc: inc, hlt: hlt, run: rn};
        v.e = '{idx: vecs.size(), bwr_chk: bchk, bwr: bwr, pc: epc, ph: eph, ins: eins,
                bd: ebd, ovf: eovf, fe: efe, hl: ehl};
        vecs.push_back(v);
    endtask

    // Post-edge comparison against the head of the scoreboard
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.idx, "pc",          32'(pc),          32'(e.pc));
            chk(e.idx, "phase",       32'(phase),       32'(e.ph));
            chk(e.idx, "instruction", 32'(instruction), 32'(e.ins));
            chk(e.idx, "boot_done",   32'(boot_done),   32'(e.bd));
            chk(e.idx, "phase_ovf",   32'(phase_ovf),   32'(e.ovf));
            chk(e.idx, "fetch_en",    32'(fetch_en),    32'(e.fe));
            chk(e.idx, "halted",      32'(halted),      32'(e.hl));
        end
    end

    initial begin
        rst = 1'b1; mem_rdy = 1'b1; databus = '0; phase_reset_req = 1'b0;
        pc_load = 1'b0; pc_load_val = '0; pc_inc = 1'b0; halt_req = 1'b0; run = 1'b0;

        //  rst rdy db     prr ld ldv     inc hlt run | bchk bwr pc      ph   ins    bd ovf fe hl
        // Reset then full-speed boot copy
        add(1, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0,   0, 0, 12'h000, 4'd0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 1, 12'h001, 4'd0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 1, 12'h002, 4'd0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 1, 12'h003, 4'd0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 1, 12'h000, 4'd0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 0, 12'h000, 4'd0, 8'h00, 1, 0, 1, 0);
        // Fetch A5, run to phase 2, end instruction
        add(0, 1, 8'hA5, 0, 0, 12'h000, 0, 0, 0,   1, 0, 12'h001, 4'd1, 8'hA5, 1, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 0, 12'h001, 4'd2, 8'hA5, 1, 0, 0, 0);
        add(0, 1, 8'h00, 1, 0, 12'h000, 0, 0, 0,   1, 0, 12'h001, 4'd0, 8'hA5, 1, 0, 1, 0);
        // Load beats inc; then jump to FFF and fetch wraps PC to 000
        add(0, 1, 8'h3C, 0, 0, 12'h000, 0, 0, 0,   1, 0, 12'h002, 4'd1, 8'h3C, 1, 0, 0, 0);
        add(0, 1, 8'h00, 1, 1, 12'h3F0, 1, 0, 0,   1, 0, 12'h3F0, 4'd0, 8'h3C, 1, 0, 1, 0);
        add(0, 1, 8'h11, 0, 0, 12'h000, 0, 0, 0,   1, 0, 12'h3F1, 4'd1, 8'h11, 1, 0, 0, 0);
        add(0, 1, 8'h00, 0, 1, 12'hFFF, 0, 0, 0,   1, 0, 12'hFFF, 4'd2, 8'h11, 1, 0, 0, 0);
        add(0, 1, 8'h00, 1, 0, 12'h000, 0, 0, 0,   1, 0, 12'hFFF, 4'd0, 8'h11, 1, 0, 1, 0);
        add(0, 1, 8'h22, 0, 0, 12'h000, 0, 0, 0,   1, 0, 12'h000, 4'd1, 8'h22, 1, 0, 0, 0);
        // pc_inc, then a wait state drops strobes, then halt outranks end-of-instruction
        add(0, 1, 8'h00, 0, 0, 12'h000, 1, 0, 0,   1, 0, 12'h001, 4'd2, 8'h22, 1, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 12'h000, 1, 0, 0,   1, 0, 12'h001, 4'd2, 8'h22, 1, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 0, 12'h001, 4'd3, 8'h22, 1, 0, 0, 0);
        add(0, 1, 8'h00, 1, 1, 12'h555, 0, 1, 0,   1, 0, 12'h001, 4'd3, 8'h22, 1, 0, 0, 1);
        add(0, 1, 8'h99, 0, 1, 12'h555, 1, 1, 0,   1, 0, 12'h001, 4'd3, 8'h22, 1, 0, 0, 1);
        add(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 1,   1, 0, 12'h001, 4'd0, 8'h22, 1, 0, 1, 0);
        // FETCH stalled by wait state; run ignored outside HALT
        add(0, 0, 8'h88, 0, 0, 12'h000, 0, 0, 1,   1, 0, 12'h001, 4'd0, 8'h22, 1, 0, 1, 0);
        // Phase overflow: 15 EXEC edges without end-of-instruction
        add(0, 1, 8'h77, 0, 0, 12'h000, 0, 0, 0,   1, 0, 12'h002, 4'd1, 8'h77, 1, 0, 0, 0);
        for (int k = 2; k <= 15; k++)
            add(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0, 1, 0, 12'h002, 4'(k), 8'h77, 1, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 0, 12'h002, 4'd0, 8'h77, 1, 1, 1, 0);
        add(0, 1, 8'h66, 0, 0, 12'h000, 0, 0, 0,   1, 0, 12'h003, 4'd1, 8'h66, 1, 1, 0, 0);
        // Reset mid-EXEC clears everything, then boot with a 2-cycle stall at pc=2
        add(1, 1, 8'h00, 0, 1, 12'h123, 0, 0, 0,   1, 0, 12'h000, 4'd0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 1, 12'h001, 4'd0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 1, 12'h002, 4'd0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 0, 12'h002, 4'd0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 0, 12'h002, 4'd0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 1, 12'h003, 4'd0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 1, 12'h000, 4'd0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 12'h000, 0, 0, 0,   1, 0, 12'h000, 4'd0, 8'h00, 1, 0, 1, 0);

        foreach (vecs[n]) begin
            @(negedge clk);
            rst             = vecs[n].i.rst;
            mem_rdy         = vecs[n].i.rdy;
            databus         = vecs[n].i.db;
            phase_reset_req = vecs[n].i.prr;
            pc_load         = vecs[n].i.ld;
            pc_load_val     = vecs[n].i.ldv;
            pc_inc          = vecs[n].i.inc;
            halt_req        = vecs[n].i.hlt;
            run             = vecs[n].i.run;
            #1;
            if (vecs[n].e.bwr_chk)
                chk(vecs[n].e.idx, "boot_wr", 32'(boot_wr), 32'(vecs[n].e.bwr));
            sbq.push_back(vecs[n].e);
        end

        @(negedge clk);
        chk(-1, "scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
